// File: rtl/sound_sequencer.sv
// Fixed-priority sound-effect player driving one speaker pin from hard-coded note tables.
// Define SOUND_PREEMPT_EN to let a higher-priority request abort the effect in progress.
module sound_sequencer #(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic       speaker_out,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);

  state_t      state, state_n;
  logic [2:0]  pending, pending_n;
  logic [1:0]  active_id_n;
  logic [1:0]  note_idx, note_idx_n;
  logic [15:0] half_period, half_period_n;
  logic [7:0]  ticks_left, ticks_left_n;
  logic [15:0] tone_cnt, tone_cnt_n;
  logic [19:0] presc, presc_n;
  logic        speaker_n;
  logic        done_n;
  logic [1:0]  sel_id;
  logic [2:0]  sel_mask;
  logic [2:0]  higher_mask;

  function automatic logic [15:0] note_half(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b0000: return 16'd28408;
      4'b0100: return 16'd14204;
      4'b0101: return 16'd28408;
      4'b1000: return 16'd18939;
      4'b1001: return 16'd25252;
      4'b1010: return 16'd37878;
      default: return 16'd28408;
    endcase
  endfunction

  function automatic logic [7:0] note_ticks(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b0000: return 8'd5;
      4'b0100: return 8'd10;
      4'b0101: return 8'd10;
      4'b1000: return 8'd20;
      4'b1001: return 8'd20;
      4'b1010: return 8'd40;
      default: return 8'd5;
    endcase
  endfunction

  function automatic logic [1:0] last_note(input logic [1:0] id);
    case (id)
      2'd1:    return 2'd1;
      2'd2:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Highest set pending bit wins; crash outranks fuel-low outranks engine beep.
  always_comb begin
    sel_id   = 2'd0;
    sel_mask = 3'b001;
    if (pending[2]) begin
      sel_id   = 2'd2;
      sel_mask = 3'b100;
    end else if (pending[1]) begin
      sel_id   = 2'd1;
      sel_mask = 3'b010;
    end
    case (active_id)
      2'd0:    higher_mask = 3'b110;
      2'd1:    higher_mask = 3'b100;
      default: higher_mask = 3'b000;
    endcase
  end

  always_comb begin
    state_n       = state;
    pending_n     = pending | req;
    active_id_n   = active_id;
    note_idx_n    = note_idx;
    half_period_n = half_period;
    ticks_left_n  = ticks_left;
    tone_cnt_n    = tone_cnt;
    presc_n       = presc;
    speaker_n     = speaker_out;
    done_n        = 1'b0;

    case (state)
      IDLE: begin
        if (pending != 3'b000) begin
          pending_n   = (pending & ~sel_mask) | req;
          active_id_n = sel_id;
          note_idx_n  = 2'd0;
          state_n     = LOAD;
        end
      end
      LOAD: begin
        half_period_n = note_half(active_id, note_idx);
        ticks_left_n  = note_ticks(active_id, note_idx);
        tone_cnt_n    = 16'd0;
        presc_n       = 20'd0;
        speaker_n     = 1'b0;
        state_n       = PLAY;
      end
      PLAY: begin
        if (tone_cnt == half_period - 16'd1) begin
          tone_cnt_n = 16'd0;
          speaker_n  = ~speaker_out;
        end else begin
          tone_cnt_n = tone_cnt + 16'd1;
        end
        if (presc == TICK_LAST) begin
          presc_n      = 20'd0;
          ticks_left_n = ticks_left - 8'd1;
          // The last tick of the note ends it, either finishing the effect or moving on.
          if (ticks_left == 8'd1) begin
            if (note_idx == last_note(active_id)) begin
              speaker_n = 1'b0;
              done_n    = 1'b1;
              state_n   = IDLE;
            end else begin
              note_idx_n = note_idx + 2'd1;
              state_n    = LOAD;
            end
          end
        end else begin
          presc_n = presc + 20'd1;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef SOUND_PREEMPT_EN
    // Aborted effects are dropped; selection of the new one happens from IDLE.
    if (state != IDLE && (pending & higher_mask) != 3'b000) begin
      speaker_n = 1'b0;
      done_n    = 1'b0;
      state_n   = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= 3'b000;
      active_id   <= 2'd0;
      note_idx    <= 2'd0;
      half_period <= 16'd0;
      ticks_left  <= 8'd0;
      tone_cnt    <= 16'd0;
      presc       <= 20'd0;
      speaker_out <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      active_id   <= active_id_n;
      note_idx    <= note_idx_n;
      half_period <= half_period_n;
      ticks_left  <= ticks_left_n;
      tone_cnt    <= tone_cnt_n;
      presc       <= presc_n;
      speaker_out <= speaker_n;
      done        <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Plays short multi-note sound effects on the single speaker pin and shares that pin among three game-event requesters (engine beep, fuel low, crash) under fixed priority. Each effect is a hard-coded table of square-wave notes, each note being a half-period in clock cycles plus a duration in ticks. The block sits between game logic and the board speaker pin and generates the tones itself with a programmable half-period counter.

## Interface
- TICK_DIV, 500000: clock cycles per duration tick (10 ms at 50 MHz); legal range 2..2^20.
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req  in  3  effect requests, sampled every edge; bit 2 = crash (highest), bit 1 = fuel low, bit 0 = engine beep (lowest).
- speaker_out  out  1  square-wave output to the speaker pin.
- busy  out  1  high while an effect is loading or playing.
- active_id  out  2  index of the current or last effect.
- done  out  1  one-cycle pulse when an effect completes normally.

## Operation
- Effect table, as (half_period, ticks) per note:
  - effect 0: (28408, 5)
  - effect 1: (14204, 10), (28408, 10)
  - effect 2: (18939, 20), (25252, 20), (37878, 40)
- Widths: half-period 16 bits, ticks 8 bits, tick prescaler 20 bits, note index 2 bits.
- pending[2:0]: each set by req[i] on any edge and cleared only when effect i is selected. Requests are sticky, so a single-cycle pulse is enough.
- FSM states: IDLE, LOAD, PLAY.
- IDLE:
  - If pending ≠ 0, select the highest set index, clear that bit, set active_id, set note_idx=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Latch half_period and ticks for (active_id, note_idx).
  - Clear the tone counter and the tick prescaler.
  - Drive speaker_out = 0.
  - Go to PLAY.
- PLAY:
  - The tone counter runs 0..half_period−1. On wrap it returns to 0 and toggles speaker_out.
  - The prescaler runs 0..TICK_DIV−1. On wrap, ticks_left decrements.
  - When the wrap brings ticks_left to 0:
    - If this is the last note: speaker_out←0, done←1, go to IDLE.
    - Otherwise: note_idx++, go to LOAD.
- busy = (state ≠ IDLE). active_id holds its value after completion.
- A request for the currently playing effect sets its pending bit, so the effect replays once afterwards.
- If req and completion happen in the same cycle, the pending bit is set and that effect is served from IDLE on the next edge.
- Multiple pulses of the same req before it is served collapse into one play.
- Reset mid-effect: everything returns to reset values on the next edge and pending is cleared. No done pulse is produced.

## Timing
- Reset values: speaker_out=0, busy=0, active_id=0, done=0, pending=0, state IDLE, all counters 0.
- Request sampled high at edge E, with the FSM idle:
  - pending set at E.
  - LOAD at E+1, with busy=1 and active_id valid.
  - PLAY at E+2.
  - First speaker toggle at E+2+half_period.
- The first note's final tick wrap falls at E+2+ticks·TICK_DIV.
- Each subsequent note adds one LOAD cycle plus ticks·TICK_DIV cycles.
- At the final tick wrap: done=1 for exactly one cycle, busy=0, speaker_out=0, all on the same edge.

## Configuration
- SOUND_PREEMPT_EN defined:
  - In LOAD or PLAY, if a pending bit with index > active_id is set, the current effect aborts on the next edge.
  - speaker_out←0, no done pulse, and the FSM goes directly to selection (IDLE behaviour in that same cycle), so LOAD of the new effect follows one edge later.
  - The aborted effect is dropped, not resumed.
  - Equal or lower pending bits wait.
- SOUND_PREEMPT_EN undefined:
  - No preemption; every effect runs to completion.
  - Higher requests wait in pending and are served by priority afterwards.

## Test plan
- Reset, then hold rst=1 for 3 cycles with req=3'b111 → all outputs 0, and pending stays 0 after rst drops.
- TICK_DIV=60000; pulse req[0] for one cycle at edge E → busy=1 at E+1; speaker toggles at E+28410, E+56818, …; done=1 only at E+300002; busy=0 from then on.
- Pulse req[1] → first note's toggles are spaced 14204 cycles for 600000 cycles, then one LOAD cycle, then 28408-cycle spacing; done after 1200003 cycles; active_id=1.
- Pulse req[0] and req[2] in the same cycle → effect 2 plays fully; effect 0 starts 2 cycles after effect 2's done (IDLE, then LOAD); two done pulses total.
- During effect 0 PLAY, pulse req[2]:
  - With SOUND_PREEMPT_EN: speaker_out=0 next edge, active_id=2 one edge later, no done for effect 0.
  - Without it: effect 0 completes with done, then effect 2 plays.
- Assert rst during effect 1's second note → next edge speaker_out=0, busy=0, active_id=0, no done; req=0 afterwards keeps the block IDLE.
